// File: rtl/alu_cmd_issuer_if.sv
// rtl/alu_cmd_issuer_if.sv - command, ALU and result signal bundle for alu_cmd_issuer
interface alu_cmd_issuer_if #(
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_opcode;
    logic [DATA_W-1:0] cmd_src1;
    logic [DATA_W-1:0] cmd_src2;

    logic [DATA_W-1:0] alu_src1;
    logic [DATA_W-1:0] alu_src2;
    logic [11:0]       alu_op;
    logic [DATA_W-1:0] alu_result;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [3:0]        res_opcode;
    logic              res_err;
    logic              res_mismatch;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_src1, cmd_src2, alu_result, res_ready,
        output cmd_ready, alu_src1, alu_src2, alu_op,
        output res_valid, res_data, res_opcode, res_err, res_mismatch
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_src1, cmd_src2, alu_result, res_ready,
        input  cmd_ready, alu_src1, alu_src2, alu_op,
        input  res_valid, res_data, res_opcode, res_err, res_mismatch
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - issues one ALU command, captures and returns its result
// Optional result self-check enabled by defining ALU_CMD_SELFCHECK_EN.
module alu_cmd_issuer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             resetn,
    alu_cmd_issuer_if.master bus,
    output logic [CNT_W-1:0] issue_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t     state;
    logic [3:0] op_q;
    logic       op_illegal;

    assign op_illegal = (op_q > 4'd11);

    function automatic logic [11:0] op_decode(input logic [3:0] opc);
        return (opc < 4'd12) ? (12'h001 << opc) : 12'h000;
    endfunction

`ifdef ALU_CMD_SELFCHECK_EN
    logic              chk_hit;
    logic [DATA_W-1:0] chk_exp;

    // Reference covers only the ops with an unambiguous definition across ALU variants
    always_comb begin
        chk_hit = 1'b1;
        chk_exp = '0;
        case (op_q)
            4'd0:    chk_exp = bus.alu_src1 + bus.alu_src2;
            4'd1:    chk_exp = bus.alu_src1 - bus.alu_src2;
            4'd2:    chk_exp = bus.alu_src1 & bus.alu_src2;
            4'd10:   chk_exp = bus.alu_src1 ^ bus.alu_src2;
            default: chk_hit = 1'b0;
        endcase
    end
`else
    assign bus.res_mismatch = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            op_q           <= '0;
            bus.cmd_ready  <= 1'b0;
            bus.alu_src1   <= '0;
            bus.alu_src2   <= '0;
            bus.alu_op     <= '0;
            bus.res_valid  <= 1'b0;
            bus.res_data   <= '0;
            bus.res_opcode <= '0;
            bus.res_err    <= 1'b0;
            issue_cnt      <= '0;
`ifdef ALU_CMD_SELFCHECK_EN
            bus.res_mismatch <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        op_q          <= bus.cmd_opcode;
                        bus.alu_src1  <= bus.cmd_src1;
                        bus.alu_src2  <= bus.cmd_src2;
                        bus.alu_op    <= op_decode(bus.cmd_opcode);
                        bus.cmd_ready <= 1'b0;
                        state         <= ISSUE;
                    end else begin
                        bus.cmd_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    bus.alu_op     <= '0;
                    bus.res_valid  <= 1'b1;
                    bus.res_data   <= op_illegal ? '0 : bus.alu_result;
                    bus.res_opcode <= op_q;
                    bus.res_err    <= op_illegal;
`ifdef ALU_CMD_SELFCHECK_EN
                    bus.res_mismatch <= chk_hit && (chk_exp != bus.alu_result);
`endif
                    state          <= HOLD;
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        issue_cnt     <= issue_cnt + CNT_W'(1);
`ifdef ALU_CMD_SELFCHECK_EN
                        bus.res_mismatch <= 1'b0;
`endif
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.alu_op    <= '0;
                    bus.cmd_ready <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the 8-bit ALU operation interface.
- Accepts binary-coded ALU commands over a valid/ready port and drives the registered operands and 12-bit one-hot alu_op into the combinational ALU.
- Captures alu_result one cycle later and returns it over a valid/ready result port.
- Sits between the lab's command source (test sequencer / switch front-end) and the ALU instance.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_opcode  in  4  binary op index 0..11; 12..15 illegal.
- cmd_src1  in  DATA_W  operand 1.
- cmd_src2  in  DATA_W  operand 2.
- alu_src1  out  DATA_W  to ALU operand 1.
- alu_src2  out  DATA_W  to ALU operand 2.
- alu_op  out  12  one-hot op select to ALU.
- alu_result  in  DATA_W  combinational result from ALU.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  DATA_W  captured result.
- res_opcode  out  4  opcode of the captured result.
- res_err  out  1  command had an illegal opcode.
- res_mismatch  out  1  self-check failure (see Optional Feature).
- issue_cnt  out  CNT_W  count of completed result handshakes.

Behaviour:
- Reset (async, resetn=0): state=IDLE; cmd_ready=0 while in reset, 1 on the first cycle after release. All other outputs 0, including alu_src1/2, alu_op, res_*, and issue_cnt.
- Reset asserted mid-operation discards any in-flight or held result immediately.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready at edge T, register opcode, src1 and src2, then go to ISSUE.
  - ISSUE (cycle T+1): cmd_ready=0. alu_src1/2 drive the registered operands. alu_op = 12'h001 << opcode for opcode 0..11, and 12'h000 for an illegal opcode. At the end of the cycle, capture res_data=alu_result (forced 0 if illegal), res_opcode, and res_err=(opcode>11), then go to HOLD.
  - HOLD (from T+2): res_valid=1; res_data, res_opcode and res_err are stable. On res_valid&&res_ready, go to IDLE, clear res_valid next cycle, and increment issue_cnt.
- alu_op is 12'h000 in every state except ISSUE; it is never multi-hot.
- alu_src1/2 hold their last values outside ISSUE.
- Latency: accept at T, result valid at T+2. Throughput: at most one command per 3 cycles; cmd_ready is 1 only in IDLE.
- cmd_valid while not in IDLE is ignored: not latched, no side effect.
- issue_cnt wraps 2^CNT_W-1 -> 0. It is not incremented on reset and counts illegal-opcode completions.

Optional Feature:
- Macro ALU_CMD_SELFCHECK_EN.
- Defined: in ISSUE, compute an internal expected value for opcodes 0 (src1+src2), 1 (src1-src2), 2 (src1&src2) and 10 (src1^src2), mod 2^DATA_W. At capture, res_mismatch = (expected != alu_result) for these opcodes, else 0. It is valid alongside res_valid and cleared in IDLE.
- Undefined: res_mismatch is tied to 0 and no checker logic is generated.

Test Plan:
- Reset release -> cmd_ready=1, res_valid=0, alu_op=12'h000, issue_cnt=0.
- Opcode 0, src1=8'h12, src2=8'h34, ALU model returns 8'h46, res_ready=1 -> alu_op=12'h001 at T+1; res_valid at T+2 with res_data=8'h46, res_opcode=0, res_err=0; issue_cnt=1.
- Opcode 11, src1=8'hA5, src2=8'h1F -> alu_op=12'h800 only during T+1; res_data equals the model output sampled at T+1.
- res_ready=0 for 5 cycles after the result, with cmd_valid held high -> res_data stable, cmd_ready=0, no second issue. Then res_ready=1 -> IDLE next cycle; asserting resetn=0 during a later HOLD drops res_valid and issue_cnt at once.
- Opcode 4'hE -> alu_op stays 12'h000; res_err=1, res_data=8'h00; issue_cnt still increments.
- With ALU_CMD_SELFCHECK_EN, opcode 1, 8'h10-8'h01, model returns 8'h0E -> res_mismatch=1. With the model returning 8'h0F -> res_mismatch=0.
